// File: rtl/reloj_timer_sequencer_if.sv
// Avalon-MM link between the timekeeping sequencer and the 16-bit interval timer.
interface reloj_timer_sequencer_if;
   logic [2:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [15:0] m_writedata;
   logic [15:0] m_readdata;

   modport master (
      output m_address,
      output m_chipselect,
      output m_write_n,
      output m_writedata,
      input  m_readdata
   );

   modport slave (
      input  m_address,
      input  m_chipselect,
      input  m_write_n,
      input  m_writedata,
      output m_readdata
   );
endinterface

// File: rtl/reloj_timer_sequencer.sv
// Drives the interval timer in continuous interrupt mode, services each timeout
// and folds the timeouts into an hours:minutes:seconds time-of-day counter.
module reloj_timer_sequencer #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int TICK_W        = 10
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           enable,
   input  logic                           set_valid,
   input  logic [4:0]                     set_hours,
   input  logic [5:0]                     set_minutes,
   input  logic [5:0]                     set_seconds,
   reloj_timer_sequencer_if.master        bus,
   input  logic                           timer_irq,
   output logic [4:0]                     hours,
   output logic [5:0]                     minutes,
   output logic [5:0]                     seconds,
   output logic                           sec_pulse,
   output logic                           busy,
   output logic                           restart_err
);

   localparam logic [2:0]        ADDR_STATUS  = 3'd0;
   localparam logic [2:0]        ADDR_CONTROL = 3'd1;
   localparam logic [15:0]       CTRL_START   = 16'h0007;
   localparam logic [15:0]       CTRL_STOP    = 16'h0008;
   localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      IDLE, CFG, RUN, ACK, SETTLE, RD, RDW, STOP
   } state_t;

   state_t            state, state_nxt;
   logic [TICK_W-1:0] tick_cnt;
   logic              run_lost;

   function automatic logic [4:0] clamp_hours(input logic [4:0] h);
      return (h > 5'd23) ? 5'd23 : h;
   endfunction

   function automatic logic [5:0] clamp_59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (enable) state_nxt = CFG;
         CFG:    state_nxt = RUN;
         RUN: begin
            if (!enable)        state_nxt = STOP;
            else if (timer_irq) state_nxt = ACK;
         end
         ACK:    state_nxt = SETTLE;
         SETTLE: state_nxt = RD;
         RD:     state_nxt = RDW;
         RDW:    state_nxt = bus.m_readdata[1] ? RUN : CFG;
         STOP:   state_nxt = IDLE;
      endcase
   end

   // Bus outputs are decoded from state so every access lasts exactly one cycle.
   always_comb begin
      bus.m_address    = '0;
      bus.m_chipselect = 1'b0;
      bus.m_write_n    = 1'b1;
      bus.m_writedata  = '0;
      busy             = (state != IDLE);
      unique case (state)
         CFG: begin
            bus.m_chipselect = 1'b1;
            bus.m_write_n    = 1'b0;
            bus.m_address    = ADDR_CONTROL;
            bus.m_writedata  = CTRL_START;
         end
         ACK: begin
            bus.m_chipselect = 1'b1;
            bus.m_write_n    = 1'b0;
            bus.m_address    = ADDR_STATUS;
         end
         RD: begin
            bus.m_chipselect = 1'b1;
            bus.m_address    = ADDR_STATUS;
         end
         STOP: begin
            bus.m_chipselect = 1'b1;
            bus.m_write_n    = 1'b0;
            bus.m_address    = ADDR_CONTROL;
            bus.m_writedata  = CTRL_STOP;
         end
         default: ;
      endcase
   end

   assign run_lost = (state == RDW) && !bus.m_readdata[1];

   // A load from set_valid wins over a same-cycle tick, which is then dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt    <= '0;
         hours       <= '0;
         minutes     <= '0;
         seconds     <= '0;
         sec_pulse   <= 1'b0;
         restart_err <= 1'b0;
      end else begin
         sec_pulse <= 1'b0;
         if (set_valid) begin
            hours       <= clamp_hours(set_hours);
            minutes     <= clamp_59(set_minutes);
            seconds     <= clamp_59(set_seconds);
            tick_cnt    <= '0;
            restart_err <= 1'b0;
         end else begin
            if (run_lost) restart_err <= 1'b1;
            if (state == ACK) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt  <= '0;
                  sec_pulse <= 1'b1;
                  if (seconds == 6'd59) begin
                     seconds <= '0;
                     if (minutes == 6'd59) begin
                        minutes <= '0;
                        hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                     end else begin
                        minutes <= minutes + 6'd1;
                     end
                  end else begin
                     seconds <= seconds + 6'd1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_reloj_timer_sequencer.sv
// Directed-plus-random bench: the bench plays the timer and tracks the expected
// time of day as a plain seconds-of-day count.
module tb_reloj_timer_sequencer;

   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       set_valid;
   logic [4:0] set_hours;
   logic [5:0] set_minutes;
   logic [5:0] set_seconds;
   logic       timer_irq;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       sec_pulse;
   logic       busy;
   logic       restart_err;

   reloj_timer_sequencer_if bus ();

   reloj_timer_sequencer #(.TICKS_PER_SEC(TPS), .TICK_W(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .set_valid   (set_valid),
      .set_hours   (set_hours),
      .set_minutes (set_minutes),
      .set_seconds (set_seconds),
      .bus         (bus),
      .timer_irq   (timer_irq),
      .hours       (hours),
      .minutes     (minutes),
      .seconds     (seconds),
      .sec_pulse   (sec_pulse),
      .busy        (busy),
      .restart_err (restart_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int exp_sod = 0;
   int exp_ticks = 0;
   bit exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_time(input string tag);
      chk({tag, "_hours"},   32'(hours),   32'(exp_sod / 3600));
      chk({tag, "_minutes"}, 32'(minutes), 32'((exp_sod / 60) % 60));
      chk({tag, "_seconds"}, 32'(seconds), 32'(exp_sod % 60));
   endtask

   task automatic chk_bus(input string tag, input bit cs, input bit wn, input int addr, input int wd);
      chk({tag, "_cs"},    32'(bus.m_chipselect), 32'(cs));
      chk({tag, "_wn"},    32'(bus.m_write_n),    32'(wn));
      chk({tag, "_addr"},  32'(bus.m_address),    32'(addr));
      chk({tag, "_wdata"}, 32'(bus.m_writedata),  32'(wd));
   endtask

   function automatic int clampv(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_load(input int h, input int m, input int s);
      exp_sod   = clampv(h, 23) * 3600 + clampv(m, 59) * 60 + clampv(s, 59);
      exp_ticks = 0;
      exp_err   = 1'b0;
   endtask

   // Called while the DUT sits in RUN with no interrupt pending.
   task automatic set_time(input int h, input int m, input int s);
      set_valid   = 1'b1;
      set_hours   = 5'(h);
      set_minutes = 6'(m);
      set_seconds = 6'(s);
      step();
      set_valid = 1'b0;
      model_load(h, m, s);
      chk_time("set");
      chk("set_err", 32'(restart_err), 32'(0));
      chk("set_pulse", 32'(sec_pulse), 32'(0));
   endtask

   task automatic run_idle(input int n);
      timer_irq = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         chk("run_cs", 32'(bus.m_chipselect), 32'(0));
         chk("run_pulse", 32'(sec_pulse), 32'(0));
      end
   endtask

   // One timer timeout, serviced from RUN back to RUN.
   task automatic do_tick(input bit run_ok, input bit drop_en, input bit do_set,
                          input int sh, input int sm, input int ss);
      bit wrap;
      timer_irq = 1'b1;
      step();
      chk_bus("ack", 1'b1, 1'b0, 0, 0);
      if (drop_en) enable = 1'b0;
      if (do_set) begin
         set_valid   = 1'b1;
         set_hours   = 5'(sh);
         set_minutes = 6'(sm);
         set_seconds = 6'(ss);
      end
      step();
      set_valid = 1'b0;
      wrap = 1'b0;
      if (do_set) begin
         model_load(sh, sm, ss);
      end else begin
         exp_ticks++;
         if (exp_ticks == TPS) begin
            exp_ticks = 0;
            exp_sod   = (exp_sod + 1) % 86400;
            wrap      = 1'b1;
         end
      end
      chk("settle_pulse", 32'(sec_pulse), 32'(wrap));
      chk("settle_cs", 32'(bus.m_chipselect), 32'(0));
      chk_time("settle");
      timer_irq = 1'b0;
      step();
      chk_bus("rd", 1'b1, 1'b1, 0, 0);
      bus.m_readdata = 16'(($urandom & 32'hFFFD) | (32'(run_ok) << 1));
      step();
      chk("rdw_cs", 32'(bus.m_chipselect), 32'(0));
      chk("rdw_pulse", 32'(sec_pulse), 32'(0));
      step();
      bus.m_readdata = 16'($urandom);
      if (!run_ok) begin
         exp_err = 1'b1;
         chk("lost_err", 32'(restart_err), 32'(1));
         chk_bus("recfg", 1'b1, 1'b0, 1, 16'h0007);
         step();
      end
      chk("back_cs", 32'(bus.m_chipselect), 32'(0));
      chk("back_busy", 32'(busy), 32'(1));
      chk("back_err", 32'(restart_err), 32'(exp_err));
   endtask

   initial begin
      int r;
      reset_n        = 1'b0;
      enable         = 1'b0;
      set_valid      = 1'b0;
      set_hours      = '0;
      set_minutes    = '0;
      set_seconds    = '0;
      timer_irq      = 1'b0;
      bus.m_readdata = '0;
      step();
      step();
      chk_bus("reset", 1'b0, 1'b1, 0, 0);
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_pulse", 32'(sec_pulse), 32'(0));
      chk("reset_err", 32'(restart_err), 32'(0));
      chk_time("reset");

      // Start-up configuration write, then RUN.
      reset_n = 1'b1;
      enable  = 1'b1;
      step();
      chk_bus("cfg", 1'b1, 1'b0, 1, 16'h0007);
      chk("cfg_busy", 32'(busy), 32'(1));
      step();
      chk_bus("run", 1'b0, 1'b1, 0, 0);
      chk("run_busy", 32'(busy), 32'(1));
      chk_time("run0");

      // One second's worth of timeouts.
      run_idle(2);
      for (int i = 0; i < TPS; i++) begin
         do_tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
         run_idle($urandom_range(0, 2));
      end
      chk("one_sec", 32'(seconds), 32'(1));

      // Midnight rollover.
      set_time(23, 59, 59);
      for (int i = 0; i < TPS; i++) do_tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
      chk_time("midnight");

      // Timer found stopped: restart and flag, then cleared by a load.
      run_idle(1);
      do_tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
      run_idle(1);
      set_time(1, 2, 3);

      // Load collides with the wrapping tick: load wins and the tick phase restarts.
      for (int i = 0; i < TPS && exp_ticks != TPS - 1; i++) do_tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
      do_tick(1'b1, 1'b0, 1'b1, 30, $urandom_range(0, 59), 10);
      chk("clamp_h", 32'(hours), 32'(23));
      chk("set_s", 32'(seconds), 32'(10));
      for (int i = 0; i < TPS; i++) do_tick(1'b1, 1'b0, 1'b0, 0, 0, 0);

      // Random mix of timeouts, lost-timer reads and (possibly out-of-range) loads.
      for (int i = 0; i < 40; i++) begin
         run_idle($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         if (r == 0)      set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
         else if (r == 1) do_tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
         else if (r == 2) do_tick(1'b1, 1'b0, 1'b1, $urandom_range(0, 31),
                                  $urandom_range(0, 63), $urandom_range(0, 63));
         else             do_tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
      end

      // Disable wins over a simultaneous interrupt.
      enable    = 1'b0;
      timer_irq = 1'b1;
      step();
      chk_bus("stop", 1'b1, 1'b0, 1, 16'h0008);
      step();
      chk("idle_busy", 32'(busy), 32'(0));
      chk_bus("idle", 1'b0, 1'b1, 0, 0);
      step();
      step();
      chk("idle_cs", 32'(bus.m_chipselect), 32'(0));
      chk_time("idle");

      // Interrupt pending since IDLE is serviced only once RUN is reached.
      enable = 1'b1;
      step();
      chk_bus("recfg2", 1'b1, 1'b0, 1, 16'h0007);
      step();
      chk("run2_cs", 32'(bus.m_chipselect), 32'(0));
      do_tick(1'b1, 1'b0, 1'b0, 0, 0, 0);

      // Disable during service: finish, return to RUN, then stop.
      run_idle(1);
      do_tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
      step();
      chk_bus("stop2", 1'b1, 1'b0, 1, 16'h0008);
      step();
      chk("idle2_busy", 32'(busy), 32'(0));
      chk_time("idle2");

      // Asynchronous reset in the middle of a bus write.
      enable = 1'b1;
      step();
      chk_bus("cfg3", 1'b1, 1'b0, 1, 16'h0007);
      #2;
      reset_n = 1'b0;
      #1;
      chk_bus("areset", 1'b0, 1'b1, 0, 0);
      chk("areset_busy", 32'(busy), 32'(0));
      chk("areset_err", 32'(restart_err), 32'(0));
      exp_sod = 0;
      chk_time("areset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
